hash_unpacker: RTL and testbench

HASH_UNPACKER -- requirements
Module: hash_unpacker

---
 rtl/hash_unpacker.sv | 183 ++++++++++++++++++
 tb/tb_hash_unpacker.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : hash_unpacker
// Description : Captures one SHA-256 digest as WORD_COUNT words, most
//               significant word first. It then streams the digest to a UART
//               transmitter one byte at a time, big-endian, using a
//               launch/done handshake. Truncated digests and words that
//               arrive while a digest is being sent raise a one-cycle error
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_dv_in,
  input  logic [DATA_WIDTH-1:0] hash_in,
  input  logic                  tx_active_in,
  input  logic                  tx_done_in,
  output logic                  tx_dv_out,
  output logic [7:0]            tx_byte_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  // Derived sizes. DATA_WIDTH/8 and WORD_COUNT are assumed to be powers of two.
  localparam int C_NUM_BYTES = (DATA_WIDTH * WORD_COUNT) / 8;
  localparam int C_BPW       = DATA_WIDTH / 8;
  localparam int C_WC_W      = $clog2(WORD_COUNT);
  localparam int C_BC_W      = $clog2(C_NUM_BYTES);
  localparam int C_BS_W      = $clog2(C_BPW);

  localparam logic [C_WC_W-1:0] C_LAST_WORD = C_WC_W'(WORD_COUNT - 1);
  localparam logic [C_BC_W-1:0] C_LAST_BYTE = C_BC_W'(C_NUM_BYTES - 1);
  localparam logic [C_WC_W-1:0] C_ONE_WORD  = C_WC_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [C_WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [C_BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  // Entry 0 holds the most significant digest word.
  logic [DATA_WIDTH-1:0]  buffer_q [WORD_COUNT];
  logic [DATA_WIDTH-1:0]  buffer_d [WORD_COUNT];
  logic                   tx_dv_q, tx_dv_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [C_WC_W-1:0]      w_word_sel;
  logic [C_BS_W-1:0]      w_byte_sel;
  logic [DATA_WIDTH-1:0]  w_cur_word;
  logic [DATA_WIDTH-1:0]  w_shifted_word;
  logic [7:0]             w_cur_byte;

  // Pick the byte at byte_cnt: upper bits choose the word, lower bits the byte within it.
  always_comb begin
    w_word_sel     = byte_cnt_q[C_BC_W-1 -: C_WC_W];
    w_byte_sel     = byte_cnt_q[C_BS_W-1:0];
    w_cur_word     = buffer_q[w_word_sel];
    w_shifted_word = w_cur_word << {w_byte_sel, 3'b000};
    w_cur_byte     = w_shifted_word[DATA_WIDTH-1 -: 8];
  end

  // Next-state, counter, buffer and registered-output computation.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    buffer_d   = buffer_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_dv_in) begin
          buffer_d[0] = hash_in;
          word_cnt_d  = C_ONE_WORD;
          state_d     = CAPTURE;
        end
      end

      CAPTURE: begin
        if (core_dv_in) begin
          buffer_d[word_cnt_q] = hash_in;
          if (word_cnt_q == C_LAST_WORD) begin
            word_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = SEND;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          // A gap in the word stream means the digest is incomplete; drop it.
          err_d      = 1'b1;
          word_cnt_d = '0;
          state_d    = IDLE;
        end
      end

      SEND: begin
        err_d = core_dv_in;
        if (!tx_active_in) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = w_cur_byte;
          state_d   = WAIT_TX;
        end
      end

      WAIT_TX: begin
        err_d = core_dv_in;
        if (tx_done_in) begin
          if (byte_cnt_q == C_LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = CLEANUP;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = SEND;
          end
        end
      end

      CLEANUP: begin
        err_d      = core_dv_in;
        word_cnt_d = '0;
        byte_cnt_d = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered copy of "not idle" so busy_out tracks the state register exactly.
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      buffer_q   <= '{default: '0};
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buffer_q   <= buffer_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_dv_out   = tx_dv_q;
  assign tx_byte_out = tx_byte_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign err_out     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_unpacker
// Description : Self-checking bench for hash_unpacker. It holds a byte-queue
//               reference model of the big-endian digest stream and a simple
//               UART responder that returns tx_done a fixed delay after each
//               launch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_unpacker;

  localparam int DW = 32;
  localparam int WC = 8;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_dv_in;
  logic [DW-1:0] hash_in;
  logic          tx_active_in;
  logic          tx_done_in;
  logic          tx_dv_out;
  logic [7:0]    tx_byte_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;

  logic resp_done;
  logic stray_done;
  assign tx_done_in = resp_done | stray_done;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc = 0;
  logic [7:0] got_q [$];
  int         dv_cyc_q [$];
  int         err_cyc_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         dv_long   = 0;
  int         hold_viol = 0;
  logic       dv_prev   = 1'b0;
  logic [7:0] last_launch = 8'h00;
  int         resp_cnt  = 0;
  int         last_word_cyc;
  int         drop_cyc;

  logic [DW-1:0] digest_words [WC];

  hash_unpacker #(.DATA_WIDTH(DW), .WORD_COUNT(WC)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_dv_in   (core_dv_in),
    .hash_in      (hash_in),
    .tx_active_in (tx_active_in),
    .tx_done_in   (tx_done_in),
    .tx_dv_out    (tx_dv_out),
    .tx_byte_out  (tx_byte_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record launches, done/err pulses and handshake violations.
  always @(negedge clk) begin
    if (tx_dv_out) begin
      got_q.push_back(tx_byte_out);
      dv_cyc_q.push_back(cyc);
    end
    if (err_out) err_cyc_q.push_back(cyc);
    if (done_out) done_cnt <= done_cnt + 1;
    if (err_out) err_cnt <= err_cnt + 1;
    if (tx_dv_out && dv_prev) dv_long <= dv_long + 1;
    if (!tx_dv_out && !rst && tx_byte_out !== last_launch) hold_viol <= hold_viol + 1;
    if (rst) last_launch <= 8'h00;
    else if (tx_dv_out) last_launch <= tx_byte_out;
    dv_prev <= tx_dv_out;
  end

  // UART responder: tx_done pulse 10 cycles after each launch.
  always @(negedge clk) begin
    if (rst) begin
      resp_cnt  <= 0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (tx_dv_out) resp_cnt <= 10;
      else if (resp_cnt > 0) begin
        resp_cnt <= resp_cnt - 1;
        if (resp_cnt == 1) resp_done <= 1'b1;
      end
    end
  end

  // Reference model: the digest leaves as bytes, most significant first.
  function automatic void model_digest();
    for (int w = 0; w < WC; w++)
      for (int b = 0; b < DW/8; b++)
        exp_q.push_back(8'((digest_words[w] >> (DW - 8 - 8*b)) & 32'hff));
  endfunction

  function automatic void load_abc();
    digest_words[0] = 32'hba7816bf; digest_words[1] = 32'h8f01cfea;
    digest_words[2] = 32'h414140de; digest_words[3] = 32'h5dae2223;
    digest_words[4] = 32'hb00361a3; digest_words[5] = 32'h96177a9c;
    digest_words[6] = 32'hb410ff61; digest_words[7] = 32'hf20015ad;
  endfunction

  function automatic void load_random();
    for (int w = 0; w < WC; w++) digest_words[w] = $urandom;
  endfunction

  task automatic drive_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      core_dv_in    = 1'b1;
      hash_in       = digest_words[i];
      last_word_cyc = cyc;
    end
    @(negedge clk);
    core_dv_in = 1'b0;
    hash_in    = $urandom;
    drop_cyc   = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_out && !tx_dv_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; core_dv_in = 1'b0; hash_in = '0; tx_active_in = 1'b0; stray_done = 1'b0;
    repeat (2) @(negedge clk);
    core_dv_in = 1'b1; hash_in = 32'hdeadbeef;
    repeat (2) @(negedge clk);
    core_dv_in = 1'b0;
    vectors++; if (tx_dv_out !== 1'b0) begin miscompares++; $display("FAIL reset_tx_dv got %b want 0", tx_dv_out); end
    vectors++; if (tx_byte_out !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte got %h want 00", tx_byte_out); end
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_out); end
    vectors++; if (done_out !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_out); end
    vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_out); end
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abc();
    int g0, d0, e0, h0, l0;
    bit ok;
    load_abc(); exp_q.delete(); model_digest();
    g0 = got_q.size(); d0 = done_cnt; e0 = err_cnt; h0 = hold_viol; l0 = dv_long;
    drive_words(WC);
    wait_idle(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abc_timeout busy=%b want idle", busy_out); end
    vectors++; if (got_q.size() - g0 != NB) begin miscompares++; $display("FAIL abc_count got %0d want %0d", got_q.size() - g0, NB); end
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (got_q.size() <= g0 + i) begin miscompares++; $display("FAIL abc_byte[%0d] missing want %h", i, exp_q[i]); end
      else if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL abc_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
    if (got_q.size() > g0) begin
      vectors++; if (got_q[g0] !== 8'hba) begin miscompares++; $display("FAIL abc_first got %h want ba", got_q[g0]); end
      vectors++; if (dv_cyc_q[g0] - last_word_cyc != 2) begin miscompares++; $display("FAIL abc_latency got %0d want 2", dv_cyc_q[g0] - last_word_cyc); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL abc_done got %0d want 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL abc_err got %0d want 0", err_cnt - e0); end
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL abc_busy_after got %b want 0", busy_out); end
    vectors++; if (dv_long - l0 != 0) begin miscompares++; $display("FAIL abc_dv_width got %0d long pulses want 0", dv_long - l0); end
    vectors++; if (hold_viol - h0 != 0) begin miscompares++; $display("FAIL abc_byte_hold got %0d changes want 0", hold_viol - h0); end
  endtask

  task automatic test_truncated();
    int g0, e0, d0;
    bit ok;
    load_random(); exp_q.delete();
    g0 = got_q.size(); e0 = err_cnt; d0 = done_cnt;
    drive_words(5);
    wait_idle(50, ok);
    repeat (20) @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL trunc_idle busy=%b want 0", busy_out); end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL trunc_err got %0d pulses want 1", err_cnt - e0); end
    if (err_cyc_q.size() > e0) begin
      vectors++; if (err_cyc_q[e0] != drop_cyc + 1) begin miscompares++; $display("FAIL trunc_err_cycle got %0d want %0d", err_cyc_q[e0], drop_cyc + 1); end
    end
    vectors++; if (got_q.size() != g0) begin miscompares++; $display("FAIL trunc_no_tx got %0d bytes want 0", got_q.size() - g0); end
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL trunc_no_done got %0d want 0", done_cnt - d0); end
    // A full digest afterwards must go through untouched.
    load_random(); model_digest();
    g0 = got_q.size();
    drive_words(WC);
    wait_idle(2000, ok);
    vectors++; if (got_q.size() - g0 != NB) begin miscompares++; $display("FAIL trunc_next_count got %0d want %0d", got_q.size() - g0, NB); end
    for (int i = 0; i < NB && g0 + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL trunc_next_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
  endtask

  task automatic test_tx_active();
    int g0, d0;
    bit ok;
    load_abc(); exp_q.delete(); model_digest();
    g0 = got_q.size(); d0 = done_cnt;
    tx_active_in = 1'b1;
    drive_words(WC);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stray_done = (i % 5 == 2);
    end
    @(negedge clk);
    stray_done = 1'b0;
    vectors++; if (got_q.size() != g0) begin miscompares++; $display("FAIL active_hold got %0d launches want 0", got_q.size() - g0); end
    tx_active_in = 1'b0;
    wait_idle(2000, ok);
    vectors++; if (got_q.size() - g0 != NB) begin miscompares++; $display("FAIL active_count got %0d want %0d", got_q.size() - g0, NB); end
    if (got_q.size() > g0) begin
      vectors++; if (got_q[g0] !== 8'hba) begin miscompares++; $display("FAIL active_first got %h want ba", got_q[g0]); end
    end
    for (int i = 0; i < NB && g0 + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL active_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL active_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_overlap();
    int g0, d0, e0;
    bit ok;
    load_random(); exp_q.delete(); model_digest();
    g0 = got_q.size(); d0 = done_cnt; e0 = err_cnt;
    drive_words(WC);
    wait_bytes(g0 + 13, 1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL overlap_reach got %0d bytes want 13", got_q.size() - g0); end
    for (int i = 0; i < WC; i++) begin
      @(negedge clk);
      core_dv_in = 1'b1;
      hash_in    = 32'h01234567;
    end
    @(negedge clk);
    core_dv_in = 1'b0;
    wait_idle(2000, ok);
    vectors++; if (err_cnt - e0 == 0) begin miscompares++; $display("FAIL overlap_err got 0 pulses want >0"); end
    vectors++; if (got_q.size() - g0 != NB) begin miscompares++; $display("FAIL overlap_count got %0d want %0d", got_q.size() - g0, NB); end
    for (int i = 0; i < NB && g0 + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL overlap_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL overlap_done got %0d want 1", done_cnt - d0); end
    repeat (20) @(negedge clk);
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL overlap_restart busy got %b want 0", busy_out); end
  endtask

  task automatic test_reset_midsend();
    int g0, d0, gr;
    bit ok;
    load_random(); exp_q.delete();
    g0 = got_q.size(); d0 = done_cnt;
    drive_words(WC);
    wait_bytes(g0 + 21, 1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_reach got %0d bytes want 21", got_q.size() - g0); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (tx_dv_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_dv got %b want 0", tx_dv_out); end
    vectors++; if (tx_byte_out !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_byte got %h want 00", tx_byte_out); end
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy_out); end
    vectors++; if (done_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", done_out); end
    vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_err got %b want 0", err_out); end
    gr = got_q.size();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    vectors++; if (got_q.size() != gr) begin miscompares++; $display("FAIL rstmid_no_tx got %0d launches want 0", got_q.size() - gr); end
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); end
    load_random(); model_digest();
    g0 = got_q.size(); d0 = done_cnt;
    drive_words(WC);
    wait_idle(2000, ok);
    vectors++; if (got_q.size() - g0 != NB) begin miscompares++; $display("FAIL rstmid_next_count got %0d want %0d", got_q.size() - g0, NB); end
    for (int i = 0; i < NB && g0 + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_next_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL rstmid_next_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int g0, d0, e0, l0;
    bit ok;
    load_random(); exp_q.delete(); model_digest();
    g0 = got_q.size(); d0 = done_cnt; e0 = err_cnt; l0 = dv_long;
    drive_words(WC);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_out) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_first_done got none want 1"); end
    load_random(); model_digest();
    drive_words(WC);
    wait_idle(2000, ok);
    vectors++; if (got_q.size() - g0 != 2*NB) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", got_q.size() - g0, 2*NB); end
    for (int i = 0; i < 2*NB && g0 + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[g0+i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_byte[%0d] got %h want %h", i, got_q[g0+i], exp_q[i]); end
    end
    vectors++; if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
    vectors++; if (dv_long - l0 != 0) begin miscompares++; $display("FAIL b2b_dv_width got %0d long pulses want 0", dv_long - l0); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_truncated();
    test_tx_active();
    test_overlap();
    test_reset_midsend();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
